pattern_loader: RTL and testbench

//  Successor to the fixed 8x8 pattern loader. Places one of 16 stored PAT_W x PAT_H seed

---
 rtl/pattern_pkg.sv | 87 ++++++++
 rtl/pattern_rom.sv | 21 ++
 rtl/pattern_loader.sv | 264 ++++++++++++++++++++++++++
 tb/tb_pattern_loader.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pattern_pkg.sv
// -----------------------------------------------------------------------------
// pattern_pkg
// Shared definitions for the pattern loader:
//   - PAT_W_DEF / PAT_H_DEF : seed bitmap dimensions (the table below is sized
//                             for these values)
//   - pat_row_t             : one bitmap row, index 0 = leftmost column
//   - state_t               : loader FSM states
//   - PATTERN_TABLE         : 16 seed bitmaps, row 0 first
//   - pat_reverse()         : left/right flip of a bitmap row (mirrored placement)
// -----------------------------------------------------------------------------
package pattern_pkg;

    localparam int PAT_W_DEF = 8;
    localparam int PAT_H_DEF = 8;
    localparam int PAT_RW    = $clog2(PAT_H_DEF);
    localparam int NUM_PAT   = 16;

    typedef logic [0:PAT_W_DEF-1] pat_row_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        FIN  = 2'd2
    } state_t;

    // Literals are written leftmost column first (MSB = column 0).
    localparam pat_row_t PATTERN_TABLE [NUM_PAT][PAT_H_DEF] = '{
        // 0: empty
        '{8'b0000_0000, 8'b0000_0000, 8'b0000_0000, 8'b0000_0000,
          8'b0000_0000, 8'b0000_0000, 8'b0000_0000, 8'b0000_0000},
        // 1: single cell
        '{8'b1000_0000, 8'b0000_0000, 8'b0000_0000, 8'b0000_0000,
          8'b0000_0000, 8'b0000_0000, 8'b0000_0000, 8'b0000_0000},
        // 2: 2x2 block
        '{8'b1100_0000, 8'b1100_0000, 8'b0000_0000, 8'b0000_0000,
          8'b0000_0000, 8'b0000_0000, 8'b0000_0000, 8'b0000_0000},
        // 3: beehive
        '{8'b0110_0000, 8'b1001_0000, 8'b0110_0000, 8'b0000_0000,
          8'b0000_0000, 8'b0000_0000, 8'b0000_0000, 8'b0000_0000},
        // 4: loaf
        '{8'b0110_0000, 8'b1001_0000, 8'b0101_0000, 8'b0010_0000,
          8'b0000_0000, 8'b0000_0000, 8'b0000_0000, 8'b0000_0000},
        // 5: boat
        '{8'b1100_0000, 8'b1010_0000, 8'b0100_0000, 8'b0000_0000,
          8'b0000_0000, 8'b0000_0000, 8'b0000_0000, 8'b0000_0000},
        // 6: tub
        '{8'b0100_0000, 8'b1010_0000, 8'b0100_0000, 8'b0000_0000,
          8'b0000_0000, 8'b0000_0000, 8'b0000_0000, 8'b0000_0000},
        // 7: horizontal blinker
        '{8'b1110_0000, 8'b0000_0000, 8'b0000_0000, 8'b0000_0000,
          8'b0000_0000, 8'b0000_0000, 8'b0000_0000, 8'b0000_0000},
        // 8: toad
        '{8'b0111_0000, 8'b1110_0000, 8'b0000_0000, 8'b0000_0000,
          8'b0000_0000, 8'b0000_0000, 8'b0000_0000, 8'b0000_0000},
        // 9: beacon
        '{8'b1100_0000, 8'b1100_0000, 8'b0011_0000, 8'b0011_0000,
          8'b0000_0000, 8'b0000_0000, 8'b0000_0000, 8'b0000_0000},
        // 10: glider
        '{8'b0100_0000, 8'b0010_0000, 8'b1110_0000, 8'b0000_0000,
          8'b0000_0000, 8'b0000_0000, 8'b0000_0000, 8'b0000_0000},
        // 11: lightweight spaceship
        '{8'b0100_1000, 8'b1000_0000, 8'b1000_1000, 8'b1111_0000,
          8'b0000_0000, 8'b0000_0000, 8'b0000_0000, 8'b0000_0000},
        // 12: R-pentomino
        '{8'b0110_0000, 8'b1100_0000, 8'b0100_0000, 8'b0000_0000,
          8'b0000_0000, 8'b0000_0000, 8'b0000_0000, 8'b0000_0000},
        // 13: diehard
        '{8'b0000_0010, 8'b1100_0000, 8'b0100_0111, 8'b0000_0000,
          8'b0000_0000, 8'b0000_0000, 8'b0000_0000, 8'b0000_0000},
        // 14: acorn
        '{8'b0100_0000, 8'b0001_0000, 8'b1100_1110, 8'b0000_0000,
          8'b0000_0000, 8'b0000_0000, 8'b0000_0000, 8'b0000_0000},
        // 15: clock oscillator
        '{8'b0010_0000, 8'b1010_0000, 8'b0101_0000, 8'b0100_0000,
          8'b0000_0000, 8'b0000_0000, 8'b0000_0000, 8'b0000_0000}
    };

    // Flip a bitmap row left/right: column c moves to PAT_W-1-c.
    function automatic pat_row_t pat_reverse(input pat_row_t row);
        pat_row_t res;
        for (int c = 0; c < PAT_W_DEF; c++) begin
            res[c] = row[PAT_W_DEF-1-c];
        end
        return res;
    endfunction

endpackage

// File: rtl/pattern_rom.sv
// -----------------------------------------------------------------------------
// pattern_rom
// Combinational lookup of one seed bitmap row.
//   i_id   : pattern index (0 = empty)
//   i_row  : bitmap row within the pattern
//   o_bits : bitmap row, index 0 = leftmost column
// -----------------------------------------------------------------------------
module pattern_rom
    import pattern_pkg::*;
(
    input  logic [3:0]        i_id,
    input  logic [PAT_RW-1:0] i_row,
    output pat_row_t          o_bits
);

    // Table read.
    always_comb begin
        o_bits = PATTERN_TABLE[i_id][i_row];
    end

endmodule

// File: rtl/pattern_loader.sv
// -----------------------------------------------------------------------------
// pattern_loader
// Places one of 16 stored seed patterns into the life grid at (x_off, y_off)
// with toroidal wrap, streaming the result as masked row writes.
//
// Ports
//   clk, rst     : clock, asynchronous active-high reset
//   start        : load request, sampled only in IDLE
//   pattern_id   : seed index (0 = empty)
//   x_off, y_off : grid position of pattern cell (0,0)
//   merge        : 1 = OR pattern rows into grid, 0 = rewrite the whole grid
//   busy         : load in progress
//   done         : one-cycle pulse after the last accepted row write
//   wr_en        : row write valid; wr_row/wr_data/wr_mask held until accepted
//   wr_ready     : grid memory accepts the row this cycle
//   wr_row       : target row
//   wr_data      : row bits, index 0 = leftmost column
//   wr_mask      : bits to update
//   mirror       : (only with PATTERN_MIRROR_EN) place the pattern flipped
//                  left/right; latched with start
//
// Configuration macro: PATTERN_MIRROR_EN adds the mirror input.
// PAT_W/PAT_H must match the bitmap size in pattern_pkg.
// -----------------------------------------------------------------------------
module pattern_loader
    import pattern_pkg::*;
#(
    parameter int GRID_W = 32,
    parameter int GRID_H = 32,
    parameter int PAT_W  = PAT_W_DEF,
    parameter int PAT_H  = PAT_H_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [3:0]                pattern_id,
    input  logic [$clog2(GRID_W)-1:0] x_off,
    input  logic [$clog2(GRID_H)-1:0] y_off,
    input  logic                      merge,
    output logic                      busy,
    output logic                      done,
    output logic                      wr_en,
    input  logic                      wr_ready,
    output logic [$clog2(GRID_H)-1:0] wr_row,
    output logic [0:GRID_W-1]         wr_data,
    output logic [0:GRID_W-1]         wr_mask
`ifdef PATTERN_MIRROR_EN
    ,
    input  logic                      mirror
`endif
);

    localparam int XW = $clog2(GRID_W);
    localparam int YW = $clog2(GRID_H);

    localparam logic [XW:0]   GRID_W_L  = (XW+1)'(GRID_W);
    localparam logic [YW:0]   GRID_H_L  = (YW+1)'(GRID_H);
    localparam logic [YW:0]   PAT_H_L   = (YW+1)'(PAT_H);
    localparam logic [YW-1:0] GRID_LAST = YW'(GRID_H - 1);
    localparam logic [YW-1:0] PAT_LAST  = YW'(PAT_H - 1);

    // Latched request and progress.
    state_t        r_state;
    logic [3:0]    r_id;
    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;
    logic          r_merge;
    logic [YW-1:0] r_cnt;
`ifdef PATTERN_MIRROR_EN
    logic          r_mirror;
`endif

    // Row generator inputs: the live request in IDLE (row 0 is prepared the
    // cycle start is accepted), otherwise the latched request and next index.
    logic [3:0]    w_sel_id;
    logic [XW-1:0] w_sel_x;
    logic [YW-1:0] w_sel_y;
    logic          w_sel_merge;
    logic          w_sel_mir;
    logic [YW-1:0] w_idx;

    logic [YW:0]      w_rel;
    logic [YW:0]      w_sum;
    logic [YW-1:0]    w_tgt;
    logic             w_in_pat;
    pat_row_t         w_rom_bits;
    pat_row_t         w_pat;
    logic [XW:0]      w_lsh;
    logic [0:GRID_W-1] w_place;
    logic [0:GRID_W-1] w_data;
    logic [0:GRID_W-1] w_mask;
    logic             w_last;

    // Select request source and the write index to prepare next.
    always_comb begin
        if (r_state == IDLE) begin
            w_sel_id    = pattern_id;
            w_sel_x     = x_off;
            w_sel_y     = y_off;
            w_sel_merge = merge;
`ifdef PATTERN_MIRROR_EN
            w_sel_mir   = mirror;
`else
            w_sel_mir   = 1'b0;
`endif
            w_idx       = '0;
        end else begin
            w_sel_id    = r_id;
            w_sel_x     = r_x;
            w_sel_y     = r_y;
            w_sel_merge = r_merge;
`ifdef PATTERN_MIRROR_EN
            w_sel_mir   = r_mirror;
`else
            w_sel_mir   = 1'b0;
`endif
            w_idx       = r_cnt + YW'(1);
        end
    end

    // Map write index to target grid row and pattern row (both wrap mod GRID_H).
    // Merge walks pattern rows; overwrite walks grid rows.
    always_comb begin
        w_sum = {1'b0, w_sel_y} + {1'b0, w_idx};
        w_rel = '0;
        w_tgt = '0;
        if (w_sel_merge) begin
            w_rel = {1'b0, w_idx};
            if (w_sum >= GRID_H_L) begin
                w_tgt = YW'(w_sum - GRID_H_L);
            end else begin
                w_tgt = w_sum[YW-1:0];
            end
        end else begin
            w_tgt = w_idx;
            if (w_idx >= w_sel_y) begin
                w_rel = {1'b0, w_idx} - {1'b0, w_sel_y};
            end else begin
                w_rel = {1'b0, w_idx} + GRID_H_L - {1'b0, w_sel_y};
            end
        end
        w_in_pat = (w_rel < PAT_H_L);
    end

    pattern_rom u_rom (
        .i_id   (w_sel_id),
        .i_row  (w_rel[PAT_RW-1:0]),
        .o_bits (w_rom_bits)
    );

    // Placement: blank rows outside the pattern, optional flip, then rotate
    // the pattern from column 0 to x so columns past the edge wrap to the left.
    always_comb begin
        if (w_in_pat) begin
            w_pat = w_rom_bits;
        end else begin
            w_pat = '0;
        end
        if (w_sel_mir) begin
            w_pat = pat_reverse(w_pat);
        end else begin
            w_pat = w_pat;
        end
        w_place            = '0;
        w_place[0:PAT_W-1] = w_pat;
        // Shift by GRID_W when x = 0 yields zero, so the wrap term vanishes.
        w_lsh  = GRID_W_L - {1'b0, w_sel_x};
        w_data = (w_place >> w_sel_x) | (w_place << w_lsh);
        if (w_sel_merge) begin
            w_mask = w_data;
        end else begin
            w_mask = '1;
        end
    end

    // Final write of the current request.
    always_comb begin
        if (r_merge) begin
            w_last = (r_cnt == PAT_LAST);
        end else begin
            w_last = (r_cnt == GRID_LAST);
        end
    end

    // Loader FSM with registered write port and status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_id     <= 4'd0;
            r_x      <= '0;
            r_y      <= '0;
            r_merge  <= 1'b0;
            r_cnt    <= '0;
`ifdef PATTERN_MIRROR_EN
            r_mirror <= 1'b0;
`endif
            busy     <= 1'b0;
            done     <= 1'b0;
            wr_en    <= 1'b0;
            wr_row   <= '0;
            wr_data  <= '0;
            wr_mask  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_id     <= pattern_id;
                        r_x      <= x_off;
                        r_y      <= y_off;
                        r_merge  <= merge;
`ifdef PATTERN_MIRROR_EN
                        r_mirror <= mirror;
`endif
                        r_cnt    <= '0;
                        busy     <= 1'b1;
                        wr_en    <= 1'b1;
                        wr_row   <= w_tgt;
                        wr_data  <= w_data;
                        wr_mask  <= w_mask;
                        r_state  <= LOAD;
                    end else begin
                        r_state  <= IDLE;
                    end
                end
                LOAD: begin
                    if (wr_ready) begin
                        if (w_last) begin
                            busy    <= 1'b0;
                            wr_en   <= 1'b0;
                            done    <= 1'b1;
                            wr_row  <= '0;
                            wr_data <= '0;
                            wr_mask <= '0;
                            r_state <= FIN;
                        end else begin
                            r_cnt   <= w_idx;
                            wr_row  <= w_tgt;
                            wr_data <= w_data;
                            wr_mask <= w_mask;
                            r_state <= LOAD;
                        end
                    end else begin
                        r_state <= LOAD;
                    end
                end
                FIN: begin
                    done    <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    wr_en   <= 1'b0;
                    wr_row  <= '0;
                    wr_data <= '0;
                    wr_mask <= '0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pattern_loader.sv
// -----------------------------------------------------------------------------
// tb_pattern_loader
// Directed, table-driven bench for pattern_loader (32x32 grid, 8x8 patterns).
// Outputs are sampled on the falling edge; inputs change 1 time unit after
// the rising edge.
// -----------------------------------------------------------------------------
module tb_pattern_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  pattern_id;
    logic [4:0]  x_off;
    logic [4:0]  y_off;
    logic        merge;
    logic        busy;
    logic        done;
    logic        wr_en;
    logic        wr_ready;
    logic [4:0]  wr_row;
    logic [0:31] wr_data;
    logic [0:31] wr_mask;
`ifdef PATTERN_MIRROR_EN
    logic        mirror;
`endif

    always #5 clk = ~clk;

    pattern_loader dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .pattern_id (pattern_id),
        .x_off      (x_off),
        .y_off      (y_off),
        .merge      (merge),
        .busy       (busy),
        .done       (done),
        .wr_en      (wr_en),
        .wr_ready   (wr_ready),
        .wr_row     (wr_row),
        .wr_data    (wr_data),
        .wr_mask    (wr_mask)
`ifdef PATTERN_MIRROR_EN
        ,
        .mirror     (mirror)
`endif
    );

    typedef struct {
        logic [3:0]  id;
        logic [4:0]  x;
        logic [4:0]  y;
        logic        mrg;
        logic [4:0]  chk_row;
        logic [31:0] exp_data;
        logic [31:0] exp_mask;
        int          exp_writes;
        int          exp_nz;
        logic [4:0]  exp_first;
    } vec_t;

    localparam int NV = 7;
    vec_t vecs [NV];

    int          checks;
    int          errors;
    int          cyc;
    int          s_cyc;
    int          wcount;
    int          done_cnt;
    int          done_cyc;
    logic [4:0]  first_row;
    logic [0:31] cap_data [32];
    logic [0:31] cap_mask [32];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: record the write port at the falling edge, return 1 unit after the rising edge.
    task automatic tick();
        @(negedge clk);
        if (!rst) begin
            if (wr_en && wr_ready) begin
                if (wcount == 0) first_row = wr_row;
                cap_data[wr_row] = wr_data;
                cap_mask[wr_row] = wr_mask;
                wcount++;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic clear_cap();
        for (int r = 0; r < 32; r++) begin
            cap_data[r] = '0;
            cap_mask[r] = '0;
        end
        wcount    = 0;
        done_cnt  = 0;
        done_cyc  = 0;
        first_row = '0;
    endtask

    // Issue a request, then scramble the inputs to show they are latched.
    task automatic start_load(input logic [3:0] id, input logic [4:0] x, input logic [4:0] y,
                              input logic m, input logic mir);
        pattern_id = id;
        x_off      = x;
        y_off      = y;
        merge      = m;
`ifdef PATTERN_MIRROR_EN
        mirror     = mir;
`else
        if (mir) $display("note: mirror request ignored in this build");
`endif
        start = 1'b1;
        tick();
        s_cyc      = cyc;
        start      = 1'b0;
        pattern_id = 4'd15;
        x_off      = 5'd17;
        y_off      = 5'd9;
        merge      = ~m;
    endtask

    // Run until done is recorded (bounded), then a few more cycles to catch a second pulse.
    task automatic wait_done(input string name, input int budget);
        int n;
        n = 0;
        while (done_cnt == 0 && n < budget) begin
            tick();
            n++;
        end
        check({name, "_done_seen"}, 64'(done_cnt != 0), 64'd1);
        repeat (3) tick();
    endtask

    function automatic int count_nz();
        int n;
        n = 0;
        for (int r = 0; r < 32; r++) begin
            if (cap_data[r] != '0) n++;
        end
        return n;
    endfunction

    initial begin
        int n;
        checks = 0; errors = 0; cyc = 0;
        rst = 1'b1; start = 1'b0; pattern_id = 4'd0; x_off = 5'd0; y_off = 5'd0;
        merge = 1'b0; wr_ready = 1'b1;
`ifdef PATTERN_MIRROR_EN
        mirror = 1'b0;
`endif
        clear_cap();

        //                id     x      y      mrg   row    data          mask          wr  nz first
        vecs[0] = '{4'd2,  5'd0,  5'd0,  1'b0, 5'd1,  32'hC000_0000, 32'hFFFF_FFFF, 32, 2, 5'd0};
        vecs[1] = '{4'd7,  5'd30, 5'd31, 1'b1, 5'd31, 32'h8000_0003, 32'h8000_0003, 8,  1, 5'd31};
        vecs[2] = '{4'd10, 5'd4,  5'd10, 1'b0, 5'd12, 32'h0E00_0000, 32'hFFFF_FFFF, 32, 3, 5'd0};
        vecs[3] = '{4'd0,  5'd3,  5'd3,  1'b1, 5'd3,  32'h0000_0000, 32'h0000_0000, 8,  0, 5'd3};
        vecs[4] = '{4'd3,  5'd29, 5'd30, 1'b1, 5'd31, 32'h8000_0004, 32'h8000_0004, 8,  3, 5'd30};
        vecs[5] = '{4'd11, 5'd0,  5'd28, 1'b0, 5'd31, 32'hF000_0000, 32'hFFFF_FFFF, 32, 4, 5'd0};
        vecs[6] = '{4'd9,  5'd31, 5'd0,  1'b0, 5'd2,  32'h6000_0000, 32'hFFFF_FFFF, 32, 4, 5'd0};

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy",  64'(busy),    64'd0);
        check("rst_done",  64'(done),    64'd0);
        check("rst_wr_en", 64'(wr_en),   64'd0);
        check("rst_row",   64'(wr_row),  64'd0);
        check("rst_data",  64'(wr_data), 64'd0);
        check("rst_mask",  64'(wr_mask), 64'd0);
        rst = 1'b0;
        tick();

        // Table of full loads with wr_ready held high.
        for (int i = 0; i < NV; i++) begin
            clear_cap();
            start_load(vecs[i].id, vecs[i].x, vecs[i].y, vecs[i].mrg, 1'b0);
            wait_done($sformatf("v%0d", i), 100);
            check($sformatf("v%0d_writes", i), 64'(wcount), 64'(vecs[i].exp_writes));
            check($sformatf("v%0d_latency", i), 64'(done_cyc - s_cyc), 64'(vecs[i].exp_writes));
            check($sformatf("v%0d_done_cnt", i), 64'(done_cnt), 64'd1);
            check($sformatf("v%0d_first_row", i), 64'(first_row), 64'(vecs[i].exp_first));
            check($sformatf("v%0d_data", i), 64'(cap_data[vecs[i].chk_row]), 64'(vecs[i].exp_data));
            check($sformatf("v%0d_mask", i), 64'(cap_mask[vecs[i].chk_row]), 64'(vecs[i].exp_mask));
            check($sformatf("v%0d_nonzero_rows", i), 64'(count_nz()), 64'(vecs[i].exp_nz));
        end

        // Reset in the middle of an overwrite, while row 5 is offered.
        clear_cap();
        start_load(4'd2, 5'd0, 5'd0, 1'b0, 1'b0);
        n = 0;
        while (!(wr_en && wr_row == 5'd5) && n < 50) begin
            tick();
            n++;
        end
        check("mid_reach_row5", 64'(wr_row), 64'd5);
        check("mid_writes_before", 64'(wcount), 64'd5);
        rst = 1'b1;
        #1;
        check("mid_rst_busy",  64'(busy),    64'd0);
        check("mid_rst_done",  64'(done),    64'd0);
        check("mid_rst_wr_en", 64'(wr_en),   64'd0);
        check("mid_rst_row",   64'(wr_row),  64'd0);
        check("mid_rst_data",  64'(wr_data), 64'd0);
        check("mid_rst_mask",  64'(wr_mask), 64'd0);
        repeat (2) tick();
        rst = 1'b0;
        repeat (4) tick();
        check("mid_no_done", 64'(done_cnt), 64'd0);
        clear_cap();
        start_load(4'd1, 5'd0, 5'd0, 1'b0, 1'b0);
        check("restart_row0", 64'(wr_row), 64'd0);
        check("restart_wr_en", 64'(wr_en), 64'd1);
        wait_done("restart", 100);
        check("restart_writes", 64'(wcount), 64'd32);
        check("restart_data0", 64'(cap_data[0]), 64'h8000_0000);

        // Back-pressure on the first merge write.
        clear_cap();
        wr_ready = 1'b0;
        start_load(4'd1, 5'd7, 5'd2, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("hold%0d_row", k),  64'(wr_row),  64'd2);
            check($sformatf("hold%0d_data", k), 64'(wr_data), 64'h0100_0000);
            check($sformatf("hold%0d_mask", k), 64'(wr_mask), 64'h0100_0000);
        end
        check("hold_no_writes", 64'(wcount), 64'd0);
        wr_ready = 1'b1;
        wait_done("hold", 100);
        check("hold_writes", 64'(wcount), 64'd8);
        check("hold_done_cnt", 64'(done_cnt), 64'd1);
        check("hold_latency", 64'(done_cyc - s_cyc), 64'd11);
        check("hold_data", 64'(cap_data[2]), 64'h0100_0000);

        // Start pulses while busy and during FIN are ignored.
        clear_cap();
        start_load(4'd1, 5'd0, 5'd0, 1'b0, 1'b0);
        repeat (3) tick();
        pattern_id = 4'd3; x_off = 5'd4; y_off = 5'd4; merge = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (done !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        check("ign_reach_fin", 64'(done), 64'd1);
        pattern_id = 4'd3; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        check("ign_busy_after", 64'(busy), 64'd0);
        check("ign_writes", 64'(wcount), 64'd32);
        check("ign_done_cnt", 64'(done_cnt), 64'd1);
        check("ign_row0", 64'(cap_data[0]), 64'h8000_0000);
        check("ign_row4", 64'(cap_data[4]), 64'd0);
        check("ign_nonzero_rows", 64'(count_nz()), 64'd1);

        // Start in the IDLE cycle right after FIN is accepted.
        clear_cap();
        start_load(4'd7, 5'd0, 5'd0, 1'b1, 1'b0);
        n = 0;
        while (done !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        check("b2b_reach_fin", 64'(done), 64'd1);
        tick();
        clear_cap();
        start_load(4'd2, 5'd3, 5'd3, 1'b1, 1'b0);
        check("b2b_busy", 64'(busy), 64'd1);
        wait_done("b2b", 100);
        check("b2b_writes", 64'(wcount), 64'd8);
        check("b2b_latency", 64'(done_cyc - s_cyc), 64'd8);
        check("b2b_row3", 64'(cap_data[3]), 64'h1800_0000);
        check("b2b_row4", 64'(cap_data[4]), 64'h1800_0000);

`ifdef PATTERN_MIRROR_EN
        // Mirrored blinker lands in columns 5..7.
        clear_cap();
        start_load(4'd7, 5'd0, 5'd4, 1'b1, 1'b1);
        wait_done("mir", 100);
        check("mir_data", 64'(cap_data[4]), 64'h0700_0000);
        check("mir_mask", 64'(cap_mask[4]), 64'h0700_0000);
        check("mir_writes", 64'(wcount), 64'd8);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
